run_controller: RTL and testbench

- Synthesizable go/done sequencer that sits directly upstream of a compiled `main` component.
- Drives the component's `reset` and `go` inputs and consumes its `done`.
- Applies a fixed-length reset phase, then holds `go` until `done` or a programmable cycle limit.
- Reports the executed cycle count, so FPGA and emulation runs get the same run/measure semantics as simulation.

---
 rtl/run_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 25 ++
 rtl/run_controller.sv | 93 +++++++++
 tb/tb_run_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller and its cycle counter.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_e;

  localparam int DEFAULT_RESET_CYCLES = 5;
  localparam int DEFAULT_CNT_W        = 64;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones. Clear wins over enable; enable low holds.
// o_inc is the value the counter would take on the next enabled edge.
module sat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_inc
);

  logic [W-1:0] r_cnt;

  assign o_inc = (&r_cnt) ? r_cnt : r_cnt + W'(1);
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_inc;
  end

endmodule

// File: rtl/run_controller.sv
// Go/done sequencer for a compiled `main`: fixed reset phase, then go until
// done or the programmable cycle limit, counting RUN cycles.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cycle_limit,
  output logic             dut_reset,
  output logic             dut_go,
  input  logic             dut_done,
  output logic             busy,
  output logic             finished,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e       r_state, w_state_nxt;
  logic [RW-1:0]    r_rst_cnt, w_rst_cnt_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_start_acc;
  logic             w_cnt_en;

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_start_acc   = 1'b0;
    w_cnt_en      = 1'b0;
    case (r_state)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          w_state_nxt   = RESET;
          w_start_acc   = 1'b1;
          w_rst_cnt_nxt = RW'(RESET_CYCLES - 1);
        end
      end
      RESET: begin
        if (abort)                 w_state_nxt = IDLE;
        else if (r_rst_cnt == '0)  w_state_nxt = RUN;
        else                       w_rst_cnt_nxt = r_rst_cnt - RW'(1);
      end
      RUN: begin
        // Every RUN edge counts, including the one that leaves RUN.
        w_cnt_en = 1'b1;
        if (abort)         w_state_nxt = IDLE;
        else if (dut_done) w_state_nxt = DONE;
        else if (r_limit != '0 && w_cnt_inc == r_limit) w_state_nxt = TIMEOUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rst_cnt <= '0;
      r_limit   <= '0;
      dut_reset <= 1'b0;
      dut_go    <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      if (w_start_acc) r_limit <= cycle_limit;
      // Outputs are registered copies of the state being entered.
      dut_reset <= (w_state_nxt == RESET);
      dut_go    <= (w_state_nxt == RUN);
      busy      <= (w_state_nxt == RESET) || (w_state_nxt == RUN);
      finished  <= (w_state_nxt == DONE);
      timed_out <= (w_state_nxt == TIMEOUT);
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .i_clr (w_start_acc),
    .i_en  (w_cnt_en),
    .o_cnt (cycle_count),
    .o_inc (w_cnt_inc)
  );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: default-width instance plus a 4-bit
// counter instance for saturation.
module tb_run_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, done = 1'b0;
  logic [63:0] limit = '0;
  logic        d_reset, d_go, busy, fin, tout;
  logic [63:0] cnt;

  logic        s_start = 1'b0, s_abort = 1'b0, s_done = 1'b0;
  logic [3:0]  s_limit = '0;
  logic        s_reset, s_go, s_busy, s_fin, s_tout;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  run_controller dut (
    .clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .cycle_limit(limit), .dut_reset(d_reset), .dut_go(d_go),
    .dut_done(done), .busy(busy), .finished(fin), .timed_out(tout),
    .cycle_count(cnt)
  );

  run_controller #(.RESET_CYCLES(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(rst_n), .start(s_start), .abort(s_abort),
    .cycle_limit(s_limit), .dut_reset(s_reset), .dut_go(s_go),
    .dut_done(s_done), .busy(s_busy), .finished(s_fin), .timed_out(s_tout),
    .cycle_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] lim);
    limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Five cycles of reset with go low, checked cycle by cycle.
  task automatic reset_phase();
    for (int i = 0; i < 5; i++) begin
      chk("rst_phase_reset", d_reset, 1);
      chk("rst_phase_go", d_go, 0);
      chk("rst_phase_busy", busy, 1);
      tick();
    end
  endtask

  // n RUN cycles with go high; done driven during cycle done_at (0 = never).
  task automatic run_cycles(input int n, input int done_at);
    for (int i = 1; i <= n; i++) begin
      chk("run_go", d_go, 1);
      chk("run_reset", d_reset, 0);
      done = (i == done_at);
      tick();
    end
    done = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_reset", d_reset, 0);
    chk("rst_go", d_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    #10 rst_n = 1'b1;
    tick();

    // 1: no limit, done on 10th RUN cycle
    do_start(64'd0);
    reset_phase();
    run_cycles(10, 10);
    chk("t1_go", d_go, 0);
    chk("t1_fin", fin, 1);
    chk("t1_tout", tout, 0);
    chk("t1_busy", busy, 0);
    chk("t1_cnt", cnt, 10);

    // 2: limit 7, done never comes
    do_start(64'd7);
    chk("t2_fin_cleared", fin, 0);
    chk("t2_cnt_cleared", cnt, 0);
    reset_phase();
    run_cycles(7, 0);
    chk("t2_go", d_go, 0);
    chk("t2_tout", tout, 1);
    chk("t2_fin", fin, 0);
    chk("t2_cnt", cnt, 7);

    // 3: limit 4 and done on the same cycle -> DONE wins
    do_start(64'd4);
    chk("t3_tout_cleared", tout, 0);
    reset_phase();
    run_cycles(4, 4);
    chk("t3_fin", fin, 1);
    chk("t3_tout", tout, 0);
    chk("t3_cnt", cnt, 4);

    // 4a: abort during 3rd RESET cycle
    do_start(64'd0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4a_reset", d_reset, 0);
    chk("t4a_go", d_go, 0);
    chk("t4a_busy", busy, 0);
    chk("t4a_cnt", cnt, 0);
    chk("t4a_fin", fin, 0);
    // 4b: abort with done and start in RUN cycle 6
    do_start(64'd0);
    reset_phase();
    run_cycles(5, 0);
    abort = 1'b1; done = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; done = 1'b0; start = 1'b0;
    chk("t4b_go", d_go, 0);
    chk("t4b_busy", busy, 0);
    chk("t4b_fin", fin, 0);
    chk("t4b_cnt", cnt, 6);
    tick();
    chk("t4b_start_dropped", d_reset, 0);
    chk("t4b_still_idle", busy, 0);

    // 5: asynchronous reset mid-RUN
    do_start(64'd0);
    reset_phase();
    run_cycles(3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_go", d_go, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", cnt, 0);
    #1 rst_n = 1'b1;
    tick();
    do_start(64'd0);
    reset_phase();
    chk("t5_restart_go", d_go, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // 6: 4-bit counter saturates at 15, then back-to-back start from DONE
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_go", s_go, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_sat_cnt", s_cnt, 15);
    chk("t6_sat_busy", s_busy, 1);
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    chk("t6_fin", s_fin, 1);
    chk("t6_fin_cnt", s_cnt, 15);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("t6_restart_cnt", s_cnt, 0);
    chk("t6_restart_reset", s_reset, 1);
    chk("t6_restart_fin", s_fin, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_reset_5th", s_reset, 1);
    tick();
    chk("t6_go_after", s_go, 1);
    chk("t6_reset_after", s_reset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
